// File: rtl/hci_package.sv
// Shared HCI types: port size descriptor and the burst issuer state encoding.
// Pure type definitions; no latency or flow control of its own.
package hci_package;

    typedef struct packed {
        int unsigned DW;
        int unsigned AW;
        int unsigned BW;
        int unsigned UW;
        int unsigned IW;
        int unsigned EW;
        int unsigned EHW;
    } hci_size_parameter_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } hci_burst_state_t;

endpackage

// File: rtl/hci_core_intf.sv
// HCI core port bundle: request channel (req/gnt handshake) and response channel.
// Response data arrives on r_valid one cycle after grant; r_ready lets the initiator stall it.
interface hci_core_intf #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32,
    parameter int unsigned BW = 8,
    parameter int unsigned UW = 1,
    parameter int unsigned IW = 1,
    parameter int unsigned EW = 1
) ();

    logic               req;
    logic               gnt;
    logic [AW-1:0]      add;
    logic               wen;
    logic [DW-1:0]      data;
    logic [DW/BW-1:0]   be;
    logic               r_ready;
    logic [UW-1:0]      user;
    logic [IW-1:0]      id;
    logic [EW-1:0]      ecc;
    logic [DW-1:0]      r_data;
    logic               r_valid;

    modport initiator (
        output req, add, wen, data, be, r_ready, user, id, ecc,
        input  gnt, r_data, r_valid
    );

    modport target (
        input  req, add, wen, data, be, r_ready, user, id, ecc,
        output gnt, r_data, r_valid
    );

endinterface

// File: rtl/hci_burst_rsp_fifo.sv
// Response beat FIFO, head shown combinationally; push-to-head latency one cycle.
// No internal backpressure: the caller bounds occupancy; push on full is accepted only with a same-cycle pop.
module hci_burst_rsp_fifo #(
    parameter int unsigned DW    = 128,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] pop_data_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: count_q alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/hci_burst_issuer.sv
// Strided read burst engine: one beat request per cycle, responses buffered and streamed out.
// Requests throttle so buffered plus in-flight beats never exceed RSP_DEPTH; rsp_ready_i low stalls issue.
module hci_burst_issuer
    import hci_package::*;
#(
    parameter int unsigned         DW            = 128,
    parameter int unsigned         AW            = 32,
    parameter int unsigned         CNT_W         = 16,
    parameter int unsigned         RSP_DEPTH     = 4,
    parameter hci_size_parameter_t HCI_SIZE_tcdm = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [AW-1:0]    base_addr_i,
    input  logic [AW-1:0]    stride_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [DW-1:0]    rsp_data_o,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    hci_core_intf.initiator  tcdm
);

    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    // An all-zero size descriptor means "inherit"; otherwise it must agree with DW/AW.
    if ((HCI_SIZE_tcdm.DW != 0 && HCI_SIZE_tcdm.DW != DW) ||
        (HCI_SIZE_tcdm.AW != 0 && HCI_SIZE_tcdm.AW != AW) ||
        (DW % 32 != 0) || (RSP_DEPTH < 2)) begin : g_param_err
        $error("hci_burst_issuer: inconsistent parameters");
    end

    hci_burst_state_t state_q, state_d;

    logic [AW-1:0]    addr_q, stride_q;
    logic [CNT_W-1:0] issue_left_q, rsp_left_q;
    logic             inflight_q, done_q;
    logic [CW-1:0]    fifo_count;
    logic [OW-1:0]    occupancy;
    logic             fifo_empty;
    logic             beat_fire, last_issue, push, pop, last_pop;
    logic             burst_start, zero_len_start;

    assign occupancy      = {1'b0, fifo_count} + OW'(inflight_q);
    assign tcdm.req       = (state_q == ISSUE) && (occupancy < OW'(RSP_DEPTH));
    assign beat_fire      = tcdm.req && tcdm.gnt;
    assign last_issue     = beat_fire && (issue_left_q == CNT_W'(1));
    // Only a response we are still waiting for may enter the buffer.
    assign push           = tcdm.r_valid && inflight_q;
    assign rsp_valid_o    = !fifo_empty;
    assign pop            = rsp_valid_o && rsp_ready_i;
    assign last_pop       = pop && (rsp_left_q == CNT_W'(1));
    assign burst_start    = (state_q == IDLE) && start_i && (len_i != '0);
    assign zero_len_start = (state_q == IDLE) && start_i && (len_i == '0);

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (burst_start) state_d = ISSUE;
                ISSUE:   if (last_issue)  state_d = DRAIN;
                DRAIN:   if (last_pop)    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q       <= '0;
            stride_q     <= '0;
            issue_left_q <= '0;
            rsp_left_q   <= '0;
            inflight_q   <= 1'b0;
            done_q       <= 1'b0;
        end else if (clear_i) begin
            addr_q       <= '0;
            stride_q     <= '0;
            issue_left_q <= '0;
            rsp_left_q   <= '0;
            inflight_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            inflight_q <= beat_fire;
            done_q     <= zero_len_start || ((state_q == DRAIN) && last_pop);
            if (burst_start) begin
                addr_q       <= base_addr_i;
                stride_q     <= stride_i;
                issue_left_q <= len_i;
                rsp_left_q   <= len_i;
            end else begin
                // Address accumulates one stride per granted beat.
                if (beat_fire) begin
                    addr_q       <= addr_q + stride_q;
                    issue_left_q <= issue_left_q - CNT_W'(1);
                end
                if (pop) rsp_left_q <= rsp_left_q - CNT_W'(1);
            end
        end
    end

    hci_burst_rsp_fifo #(
        .DW    (DW),
        .DEPTH (RSP_DEPTH),
        .CW    (CW)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .push_i      (push),
        .push_data_i (tcdm.r_data),
        .pop_i       (pop),
        .pop_data_o  (rsp_data_o),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign tcdm.add     = addr_q;
    assign tcdm.wen     = 1'b1;
    assign tcdm.be      = '1;
    assign tcdm.data    = '0;
    assign tcdm.user    = '0;
    assign tcdm.id      = '0;
    assign tcdm.ecc     = '0;
    assign tcdm.r_ready = 1'b1;

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

endmodule

// File: doc/hci_burst_issuer.md
HCI_BURST_ISSUER -- requirements
Module: hci_burst_issuer

Interface
REQ-001 SHALL have parameter DW, default 128: tcdm data width in bits, multiple of 32.
REQ-002 SHALL have parameter AW, default 32: byte-address width.
REQ-003 SHALL have parameter CNT_W, default 16: width of the beat counter.
REQ-004 SHALL have parameter RSP_DEPTH, default 4: response buffer depth in beats, >=2.
REQ-005 SHALL have parameter HCI_SIZE_tcdm, default '0: hci_size_parameter_t for the tcdm port, with DW/AW matching DW/AW.
REQ-006 SHALL have port clk_i, input, 1: single clock; one clock, all state on its rising edge.
REQ-007 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port clear_i, input, 1: synchronous soft clear.
REQ-009 SHALL have port start_i, input, 1: launch a burst; sampled only in IDLE.
REQ-010 SHALL have port base_addr_i, input, AW: byte address of beat 0.
REQ-011 SHALL have port stride_i, input, AW: byte increment between beats.
REQ-012 SHALL have port len_i, input, CNT_W: number of beats.
REQ-013 SHALL have port busy_o, output, 1: high outside IDLE.
REQ-014 SHALL have port done_o, output, 1: one-cycle pulse at burst completion.
REQ-015 SHALL have port rsp_data_o, output, DW: response beat.
REQ-016 SHALL have port rsp_valid_o, output, 1: response beat valid.
REQ-017 SHALL have port rsp_ready_i, input, 1: response consumer ready.
REQ-018 SHALL have port tcdm, hci_core_intf.initiator, -: wide read port feeding hci_router.

Function
REQ-019 SHALL implement states IDLE, ISSUE, DRAIN; IDLE->ISSUE on start_i with len_i>0; ISSUE->DRAIN on grant of last beat; DRAIN->IDLE when last response popped by consumer.
REQ-020 SHALL, on start_i with len_i==0, stay IDLE, issue nothing, and pulse done_o the next cycle.
REQ-021 SHALL ignore start_i outside IDLE.
REQ-022 SHALL drive tcdm.add = base_addr_i + k*stride_i (mod 2^AW) for beat k, computed by an accumulating adder, no multiplier.
REQ-023 SHALL drive tcdm.wen=1, be='1, data='0, user/id/ecc='0, r_ready=1 constantly.
REQ-024 SHALL assert tcdm.req only in ISSUE and only when (fifo_count + inflight) < RSP_DEPTH, inflight = registered (req & gnt) of the previous cycle.
REQ-025 SHALL hold add stable while req is high and not granted; advance beat on req & gnt.
REQ-026 SHALL push tcdm.r_data into the response FIFO on tcdm.r_valid, exactly one cycle after grant; FIFO overflow SHALL be impossible by REQ-024.
REQ-027 SHALL support simultaneous push and pop on the same cycle, count unchanged.
REQ-028 SHALL present FIFO head on rsp_data_o with rsp_valid_o = !empty; pop on rsp_valid_o & rsp_ready_i.
REQ-029 SHALL pulse done_o the cycle after the final pop; busy_o drops the same cycle.
REQ-030 SHALL sustain one grant per cycle when rsp_ready_i is held high and gnt is high.
REQ-031 SHALL, on clear_i, return to IDLE, flush the FIFO, zero counters, discard any in-flight r_valid the next cycle, no done_o pulse.

Reset
REQ-032 SHALL, on rst_ni low, asynchronously set state IDLE, counters/address/inflight 0, FIFO empty: busy_o=0, done_o=0, rsp_valid_o=0, tcdm.req=0.
REQ-033 SHALL abandon a burst interrupted by reset mid-operation with no further requests after release.

Structure
REQ-034 SHALL place the state enum hci_burst_state_t in hci_package; all else local.
REQ-035 SHALL use one sub-module, hci_burst_rsp_fifo (DW wide, RSP_DEPTH deep, count output).

Verification
REQ-036 SHALL verify: base=0x100, stride=0x10, len=4, gnt=1, ready=1 -> adds 0x100,0x110,0x120,0x130 on 4 consecutive cycles, done_o 1 cycle after 4th pop.
REQ-037 SHALL verify: len=8, rsp_ready_i=0 -> exactly 4 grants then req low; ready=1 resumes, all 8 beats in order.
REQ-038 SHALL verify: gnt low 3 cycles at beat 2 -> add held at beat-2 value, no beat skipped or duplicated.
REQ-039 SHALL verify: base=0xFFFFFFF0, stride=0x10, len=2 -> adds 0xFFFFFFF0, 0x00000000.
REQ-040 SHALL verify: len=0 -> no req, done_o pulse next cycle; start_i while busy -> ignored.
REQ-041 SHALL verify: clear_i after 3 of 6 grants -> IDLE next cycle, FIFO empty, late r_valid dropped, no done_o.
